// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_arb_pkg;

  localparam int ADDR_W                 = 12;
  localparam int DATA_W                 = 32;
  localparam int NUM_REQ                = 2;
  localparam int NUM_SLAVES             = 6;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Slave index lives in the top nibble of the address; only 0..NUM_SLAVES-1 exist.
  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1 -: 4] < 4'(NUM_SLAVES));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = requester 1 was granted last; reset value makes requester 0 win the first tie.
  logic last_r;

  // Combinational grant: a lone request always wins, a tie alternates.
  always_comb begin
    grant = 2'b00;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember which requester was granted when the grant is actually consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (advance) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Arbitrates two requesters onto one APB master port, one transfer at a time,
// with address decode, error reporting and an ACCESS-phase timeout.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_W-1:0]          paddr,
  output logic                       pwrite,
  output logic [DATA_W-1:0]          pwdata,
  output logic                       psel,
  output logic                       penable,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  state_t              state_r;
  logic                owner_r;
  logic                mapped_r;
  logic [7:0]          wait_r;
  logic [1:0]          grant_s;
  logic                accept_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                write_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [NUM_REQ-1:0]  owner_onehot_s;

  // A request is accepted only in IDLE and never while reset is held.
  assign accept_s       = (state_r == ST_IDLE) && (req_valid != 2'b00) && !rst;
  assign req_ready      = accept_s ? grant_s : 2'b00;
  assign owner_onehot_s = owner_r ? 2'b10 : 2'b01;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .request (req_valid),
    .advance (accept_s),
    .grant   (grant_s)
  );

  // Select the fields of the requester that would win this cycle.
  always_comb begin
    addr_s  = req_addr[ADDR_W-1:0];
    write_s = req_write[0];
    wdata_s = req_wdata[DATA_W-1:0];
    if (grant_s[1]) begin
      addr_s  = req_addr[2*ADDR_W-1:ADDR_W];
      write_s = req_write[1];
      wdata_s = req_wdata[2*DATA_W-1:DATA_W];
    end else begin
      addr_s  = req_addr[ADDR_W-1:0];
      write_s = req_write[0];
      wdata_s = req_wdata[DATA_W-1:0];
    end
  end

  // Transfer FSM; every APB and response output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      mapped_r  <= 1'b0;
      wait_r    <= 8'd0;
      rsp_valid <= 2'b00;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      paddr     <= 12'd0;
      pwrite    <= 1'b0;
      pwdata    <= 32'd0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid <= 2'b00;
          if (accept_s) begin
            owner_r  <= grant_s[1];
            paddr    <= addr_s;
            pwrite   <= write_s;
            pwdata   <= wdata_s;
            mapped_r <= addr_mapped(addr_s);
            psel     <= addr_mapped(addr_s);
            penable  <= 1'b0;
            wait_r   <= 8'd0;
            state_r  <= ST_SETUP;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (mapped_r) begin
            penable <= 1'b1;
            state_r <= ST_ACCESS;
          end else begin
            // Unmapped slave: never touch the bus, answer with an error.
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= owner_onehot_s;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
            state_r   <= ST_RESP;
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= owner_onehot_s;
            rsp_rdata <= pwrite ? 32'd0 : prdata;
            rsp_err   <= pslverr;
            state_r   <= ST_RESP;
          end else if (wait_r == 8'(TIMEOUT_CYCLES - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= owner_onehot_s;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            wait_r    <= wait_r + 8'd1;
            state_r   <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          rsp_valid <= 2'b00;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          rsp_valid <= 2'b00;
          psel      <= 1'b0;
          penable   <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed, table-driven bench for apb_master_arbiter with a small APB slave responder.
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [23:0] addr;
    logic [1:0]  write;
    logic [63:0] wdata;
    int          waits;      // ACCESS cycles with pready low; 255 = never ready
    logic [31:0] prdata;
    logic        slverr;
    logic [1:0]  exp_grant;
    int          exp_lat;    // accept cycle to rsp_valid cycle
    logic        exp_psel;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One complete transfer: drive the request, act as APB slave, then compare.
  task automatic do_xfer(input vec_t v, input string tag);
    int          cyc;
    int          acc_cnt;
    int          lat;
    logic        done;
    logic [1:0]  rr0;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        er;
    logic        psel_seen;
    logic        psel1;
    logic        pen1;
    logic        pen2;
    logic [11:0] pa1;
    logic        pw1;
    logic [31:0] pwd1;
    logic [31:0] pwd2;
    logic        sel;
    logic [11:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_write;
    sel       = v.exp_grant[1];
    exp_addr  = sel ? v.addr[23:12] : v.addr[11:0];
    exp_wdata = sel ? v.wdata[63:32] : v.wdata[31:0];
    exp_write = sel ? v.write[1] : v.write[0];
    req_valid = v.valid;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    prdata    = v.prdata;
    pslverr   = v.slverr;
    pready    = 1'b0;
    done = 1'b0; cyc = 0; acc_cnt = 0; lat = -1; psel_seen = 1'b0;
    rr0 = 2'b00; rv = 2'b00; rd = 32'd0; er = 1'b0;
    psel1 = 1'b0; pen1 = 1'b0; pen2 = 1'b0; pa1 = 12'd0; pw1 = 1'b0; pwd1 = 32'd0; pwd2 = 32'd0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (cyc == 0) rr0 = req_ready;
      if (cyc == 1) begin psel1 = psel; pen1 = penable; pa1 = paddr; pw1 = pwrite; pwd1 = pwdata; end
      if (cyc == 2) begin pen2 = penable; pwd2 = pwdata; end
      if (psel) psel_seen = 1'b1;
      if (rsp_valid != 2'b00) begin
        done = 1'b1; lat = cyc; rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
      end
      @(posedge clk); #1;
      if (cyc == 0) req_valid = 2'b00;
      if (psel && penable) begin
        pready = (acc_cnt == v.waits);
        acc_cnt++;
      end else begin
        pready = 1'b0;
      end
      cyc++;
    end
    pready = 1'b0;
    check({tag, " grant"},   64'(rr0), 64'(v.exp_grant));
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " rsp_valid"}, 64'(rv), 64'(v.exp_grant));
    check({tag, " rsp_rdata"}, 64'(rd), 64'(v.exp_rdata));
    check({tag, " rsp_err"},   64'(er), 64'(v.exp_err));
    check({tag, " psel_seen"}, 64'(psel_seen), 64'(v.exp_psel));
    check({tag, " psel_setup"}, 64'(psel1), 64'(v.exp_psel));
    check({tag, " penable_setup"}, 64'(pen1), 64'(0));
    check({tag, " penable_access"}, 64'(pen2), 64'(v.exp_psel));
    if (v.exp_psel) begin
      check({tag, " paddr"},  64'(pa1), 64'(exp_addr));
      check({tag, " pwrite"}, 64'(pw1), 64'(exp_write));
      check({tag, " pwdata"}, 64'(pwd1), 64'(exp_wdata));
      check({tag, " pwdata_stable"}, 64'(pwd2), 64'(exp_wdata));
    end
    // Response must be a single-cycle pulse; this cycle is IDLE again.
    @(negedge clk);
    check({tag, " rsp_pulse_end"}, 64'(rsp_valid), 64'(0));
    check({tag, " psel_idle"}, 64'(psel), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    logic any_rsp;
    // valid, addr{r1,r0}, write, wdata{r1,r0}, waits, prdata, slverr, grant, lat, psel, rdata, err
    vecs[0]  = '{2'b11, {12'h400, 12'h000}, 2'b00, 64'h0, 0, 32'h11, 1'b0, 2'b01, 3, 1'b1, 32'h11, 1'b0};
    vecs[1]  = '{2'b10, {12'h400, 12'h000}, 2'b00, 64'h0, 0, 32'h22, 1'b0, 2'b10, 3, 1'b1, 32'h22, 1'b0};
    vecs[2]  = '{2'b01, {12'h000, 12'h300}, 2'b01, {32'h0, 32'd13}, 0, 32'h99, 1'b0, 2'b01, 3, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{2'b11, {12'h400, 12'h000}, 2'b00, 64'h0, 0, 32'h33, 1'b0, 2'b10, 3, 1'b1, 32'h33, 1'b0};
    vecs[4]  = '{2'b01, {12'h400, 12'h000}, 2'b00, 64'h0, 0, 32'h44, 1'b0, 2'b01, 3, 1'b1, 32'h44, 1'b0};
    vecs[5]  = '{2'b10, {12'h100, 12'h000}, 2'b00, 64'h0, 2, 32'hA5, 1'b0, 2'b10, 5, 1'b1, 32'hA5, 1'b0};
    vecs[6]  = '{2'b01, {12'h000, 12'h600}, 2'b00, 64'h0, 0, 32'hFF, 1'b0, 2'b01, 2, 1'b0, 32'h0, 1'b1};
    vecs[7]  = '{2'b10, {12'hF00, 12'h000}, 2'b10, {32'h77, 32'h0}, 0, 32'hFF, 1'b0, 2'b10, 2, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{2'b01, {12'h000, 12'h200}, 2'b00, 64'h0, 255, 32'hDEAD, 1'b0, 2'b01, 18, 1'b1, 32'h0, 1'b1};
    vecs[9]  = '{2'b10, {12'h5FC, 12'h000}, 2'b00, 64'h0, 1, 32'h77, 1'b1, 2'b10, 4, 1'b1, 32'h77, 1'b1};
    vecs[10] = '{2'b01, {12'h000, 12'h504}, 2'b01, {32'h0, 32'hCAFE}, 0, 32'h1234, 1'b0, 2'b01, 3, 1'b1, 32'h0, 1'b0};
    vecs[11] = '{2'b10, {12'h2A0, 12'h000}, 2'b00, 64'h0, 15, 32'hBEEF, 1'b0, 2'b10, 18, 1'b1, 32'hBEEF, 1'b0};

    rst = 1'b1; req_valid = 2'b11; req_addr = 24'h400000; req_write = 2'b11;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset rsp", 64'({rsp_valid, rsp_rdata, rsp_err}), 64'(0));
    check("reset apb", 64'({paddr, pwrite, pwdata, psel, penable}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;

    for (int i = 0; i < 12; i++) begin
      do_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while in ACCESS: bus drops at once, the transfer is never answered.
    req_valid = 2'b01; req_addr = 24'h000100; req_write = 2'b00; pready = 1'b0;
    @(negedge clk);
    check("rstmid accept", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1; req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid in_access", 64'({psel, penable}), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    check("rstmid bus_drop", 64'({psel, penable}), 64'(0));
    any_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) any_rsp = 1'b1;
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || psel) any_rsp = 1'b1;
    end
    check("rstmid no_rsp", 64'(any_rsp), 64'(0));
    @(posedge clk); #1;
    // Pointer was reset: requester 0 must win this tie even though it was granted last.
    v = '{2'b11, {12'h400, 12'h000}, 2'b00, 64'h0, 0, 32'h5A, 1'b0, 2'b01, 3, 1'b1, 32'h5A, 1'b0};
    do_xfer(v, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles before forced termination (range 2..255).
REQ-002 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 2, per-requester transfer request (bit0 = requester 0).
REQ-005 SHALL have port req_ready, output, 2, one-cycle accept pulse per requester.
REQ-006 SHALL have port req_addr, input, 24, two 12-bit addresses, requester 0 in [11:0].
REQ-007 SHALL have port req_write, input, 2, 1 = write, 0 = read.
REQ-008 SHALL have port req_wdata, input, 64, two 32-bit write words, requester 0 in [31:0].
REQ-009 SHALL have port rsp_valid, output, 2, one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port rsp_rdata, output, 32, read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1, error flag, valid with rsp_valid.
REQ-012 SHALL have port paddr, output, 12, APB address to interconnect.
REQ-013 SHALL have port pwrite, output, 1, APB direction.
REQ-014 SHALL have port pwdata, output, 32, APB write data.
REQ-015 SHALL have port psel, output, 1, APB select; interconnect decodes paddr[11:8].
REQ-016 SHALL have port penable, output, 1, APB enable.
REQ-017 SHALL have port prdata, input, 32, APB read data.
REQ-018 SHALL have port pready, input, 1, APB ready.
REQ-019 SHALL have port pslverr, input, 1, APB slave error.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-021 IDLE: any req_valid set -> grant one, pulse its req_ready, register addr/write/wdata and owner, go SETUP; none -> stay.
REQ-022 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; the single requester always wins.
REQ-023 Requester SHALL hold valid and fields stable until req_ready; deasserting earlier is ignored.
REQ-024 Decode: paddr[11:8] in 0..5 is mapped; 6..15 is unmapped.
REQ-025 Unmapped grant: SETUP skips the APB bus (psel stays 0) and goes RESP with rsp_err=1, rsp_rdata=0.
REQ-026 SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from registers; next state ACCESS.
REQ-027 ACCESS: psel=1, penable=1; pready=1 -> capture prdata (reads only; writes capture 0) and pslverr, go RESP.
REQ-028 ACCESS with pready=0 SHALL increment a wait counter; when it reaches TIMEOUT_CYCLES-1 without pready, go RESP with rsp_err=1, rsp_rdata=0.
REQ-029 RESP: pulse rsp_valid of owner for exactly one cycle with captured rdata/err, psel=penable=0; next state IDLE.
REQ-030 Minimum transfer latency: accept cycle to rsp_valid = 3 cycles (IDLE, SETUP, ACCESS with pready=1, rsp in RESP).
REQ-031 paddr/pwrite/pwdata SHALL remain stable from SETUP through the end of ACCESS.
REQ-032 At most one transfer SHALL be in flight; req_ready SHALL only pulse in IDLE.
REQ-033 Wait counter SHALL clear on entry to SETUP; no wrap-around.

Reset
REQ-034 rst=1 SHALL immediately force IDLE and zero every output: req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, psel, penable.
REQ-035 Reset mid-transfer SHALL abandon it with no rsp_valid; the round-robin pointer resets so requester 0 wins the first tie.

Structure
REQ-036 Package apb_arb_pkg SHALL hold the state enum, ADDR_W=12, DATA_W=32, NUM_REQ=2, NUM_SLAVES=6, and the default TIMEOUT_CYCLES.
REQ-037 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (request[1:0], advance, grant[1:0]).

Verification
REQ-038 Single write: req0 addr 0x300, wdata 13, pready=1 -> psel at +1, penable at +2, rsp_valid[0] at +3, rsp_err=0.
REQ-039 Read with 2 wait states: req1 addr 0x100, pready low 2 ACCESS cycles, prdata=0xA5 -> rsp_rdata=0xA5 at +5.
REQ-040 Contention: both valid from reset, addrs 0x000 and 0x400 -> req0 served first, then req1; repeat -> req1 first.
REQ-041 Unmapped: req0 addr 0x600 -> psel never rises, rsp_err=1, rsp_rdata=0.
REQ-042 Timeout: pready held 0 -> rsp_err=1 after TIMEOUT_CYCLES ACCESS cycles; pslverr=1 with pready -> rsp_err=1.
REQ-043 Reset in ACCESS: rst asserted -> psel/penable 0 same cycle, no rsp_valid; next request completes normally.
